// File: rtl/decoder_strobe_sequencer_pkg.sv
// Shared definitions for the decoder strobe sequencer:
// FSM encodings, index width and counter reload helper.
package decoder_strobe_sequencer_pkg;

    localparam int IDX_W = 2;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_GAP    = 2'd3
    } state_e;

    // Down-counter runs n..1 as n-1..0, so reload with n-1
    function automatic logic [3:0] ld_val(input int n);
        return (n > 0) ? 4'(n - 1) : 4'd0;
    endfunction

endpackage

// File: rtl/decoder_strobe_sequencer_fifo.sv
// Request buffer: DEPTH x 2-bit circular FIFO with
// wrap-around pointers and an occupancy count.
module addr_fifo
    import decoder_strobe_sequencer_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  idx_t          wdata,
    input  logic          pop,
    output idx_t          rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    idx_t          mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          do_push;
    logic          do_pop;

    // A full FIFO refuses a push even when a pop lands on the same edge
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rp];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wp] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wp <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/decoder_strobe_sequencer.sv
// Replays buffered 2-bit selects onto the 2-to-4 decoder as
// glitch-free strobes: address setup, enable pulse, hold gap.
module decoder_strobe_sequencer
    import decoder_strobe_sequencer_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    input  logic [IDX_W-1:0]       req_addr,
    output logic                   req_ready,
    output logic                   address0,
    output logic                   address1,
    output logic                   enable,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam logic [3:0] PULSE_LD = ld_val(PULSE_CYCLES);
    localparam logic [3:0] GAP_LD   = ld_val(GAP_CYCLES);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    idx_t       addr_q, addr_d;
    logic       en_q, busy_q;
    logic       pop;
    logic       fetch;
    logic       full;
    logic       empty;
    idx_t       head;

    addr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_valid && !full),
        .wdata (req_addr),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    assign req_ready = !full;
    assign address0  = addr_q[0];
    assign address1  = addr_q[1];
    assign enable    = en_q;
    assign busy      = busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        pop     = 1'b0;
        fetch   = 1'b0;
        unique case (state_q)
            ST_IDLE:   fetch = 1'b1;
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = PULSE_LD;
            end
            ST_STROBE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (GAP_CYCLES != 0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    fetch = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    fetch = 1'b1;
                end
            end
        endcase
        // Address only moves here, one cycle ahead of enable
        if (fetch) begin
            if (!empty) begin
                pop     = 1'b1;
                addr_d  = head;
                state_d = ST_SETUP;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            en_q    <= (state_d == ST_STROBE);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_decoder_strobe_sequencer.sv
// Directed bench: three sequencer configurations, hand-computed
// strobe timing, ordering and address-stability expectations.
module tb_decoder_strobe_sequencer;

    typedef struct {
        int         d;
        logic [1:0] a;
        int         c;
    } rise_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vld  [3];
    logic [1:0] ad   [3];
    logic       rdy  [3];
    logic       a0   [3];
    logic       a1   [3];
    logic       en   [3];
    logic       bsy  [3];
    logic [2:0] cnt  [3];

    int         err_cnt = 0;
    int         chk_cnt = 0;
    int         cyc     = 0;
    int         viol [3];
    logic       en_p [3];
    logic [1:0] ad_p [3];
    rise_t      rq   [$];
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    decoder_strobe_sequencer #(
        .DEPTH(4), .PULSE_CYCLES(2), .GAP_CYCLES(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(vld[0]), .req_addr(ad[0]),
        .req_ready(rdy[0]),
        .address0(a0[0]), .address1(a1[0]),
        .enable(en[0]), .busy(bsy[0]),
        .fifo_count(cnt[0])
    );

    decoder_strobe_sequencer #(
        .DEPTH(4), .PULSE_CYCLES(15), .GAP_CYCLES(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(vld[1]), .req_addr(ad[1]),
        .req_ready(rdy[1]),
        .address0(a0[1]), .address1(a1[1]),
        .enable(en[1]), .busy(bsy[1]),
        .fifo_count(cnt[1])
    );

    decoder_strobe_sequencer #(
        .DEPTH(4), .PULSE_CYCLES(1), .GAP_CYCLES(0)
    ) dut_c (
        .clk(clk), .rst_n(rst_n),
        .req_valid(vld[2]), .req_addr(ad[2]),
        .req_ready(rdy[2]),
        .address0(a0[2]), .address1(a1[2]),
        .enable(en[2]), .busy(bsy[2]),
        .fifo_count(cnt[2])
    );

    function automatic logic [1:0] addr(input int d);
        return {a1[d], a0[d]};
    endfunction

    // Record strobe starts; flag any address move while enable is high
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst_n) begin
                if (en[d] && addr(d) != ad_p[d]) viol[d]++;
                if (en[d] && !en_p[d]) rq.push_back('{d, addr(d), cyc});
                en_p[d] = en[d];
            end else begin
                en_p[d] = 1'b0;
            end
            ad_p[d] = addr(d);
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input logic [1:0] a);
        int w;
        vld[d] = 1'b1;
        ad[d]  = a;
        w = 0;
        while (!rdy[d] && w < 100) begin
            tick();
            w++;
        end
        if (w >= 100) chk("push_timeout", 32'(w), 32'd0);
        tick();
        vld[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int w;
        w = 0;
        while ((bsy[d] || cnt[d] != 3'd0) && w < 500) begin
            tick();
            w++;
        end
        chk("drain_done", 32'(w < 500), 32'd1);
    endtask

    task automatic chk_order(input int d, input int gap);
        int n;
        int lastc;
        n = 0;
        lastc = -1;
        foreach (rq[i]) begin
            if (rq[i].d == d) begin
                if (n < exp_q.size())
                    chk($sformatf("order%0d", n), 32'(rq[i].a), 32'(exp_q[n]));
                if (gap > 0 && lastc >= 0)
                    chk($sformatf("interval%0d", n), 32'(rq[i].c - lastc), 32'(gap));
                lastc = rq[i].c;
                n++;
            end
        end
        chk("rise_count", 32'(n), 32'(exp_q.size()));
        rq.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic seen;
        for (int d = 0; d < 3; d++) begin
            vld[d]  = 1'b0;
            ad[d]   = 2'd0;
            viol[d] = 0;
        end
        rst_n = 1'b0;
        #12;
        chk("rst_enable", en[0], 1'b0);
        chk("rst_addr", addr(0), 2'd0);
        chk("rst_busy", bsy[0], 1'b0);
        chk("rst_count", cnt[0], 3'd0);
        chk("rst_ready", rdy[0], 1'b1);
        rst_n = 1'b1;

        // Single request, index 2
        push(0, 2'd2);
        chk("s_e0_count", cnt[0], 3'd1);
        chk("s_e0_busy", bsy[0], 1'b0);
        tick();
        chk("s_e1_addr", addr(0), 2'd2);
        chk("s_e1_busy", bsy[0], 1'b1);
        chk("s_e1_en", en[0], 1'b0);
        tick();
        chk("s_e2_en", en[0], 1'b1);
        tick();
        chk("s_e3_en", en[0], 1'b1);
        chk("s_e3_addr", addr(0), 2'd2);
        tick();
        chk("s_e4_en", en[0], 1'b0);
        chk("s_e4_busy", bsy[0], 1'b1);
        tick();
        chk("s_e5_busy", bsy[0], 1'b0);
        rq.delete();

        // Back-to-back 0..3
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b_ready%0d", i), rdy[0], 1'b1);
            push(0, 2'(i));
        end
        drain(0);
        exp_q = {2'd0, 2'd1, 2'd2, 2'd3};
        chk_order(0, 4);

        // Push coinciding with pop at count 2
        push(0, 2'd3);
        push(0, 2'd1);
        push(0, 2'd2);
        chk("pp_count_a", cnt[0], 3'd2);
        tick();
        tick();
        chk("pp_count_b", cnt[0], 3'd2);
        push(0, 2'd0);
        chk("pp_count_c", cnt[0], 3'd2);
        chk("pp_addr", addr(0), 2'd1);
        drain(0);
        exp_q = {2'd3, 2'd1, 2'd2, 2'd0};
        chk_order(0, 4);

        // Ten requests through the pointers
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            push(0, 2'((i * 3 + 1) % 4));
            exp_q.push_back(2'((i * 3 + 1) % 4));
        end
        drain(0);
        chk_order(0, 4);
        chk("a_addr_stable", 32'(viol[0]), 32'd0);

        // Asynchronous reset in the middle of a strobe
        push(0, 2'd3);
        push(0, 2'd1);
        tick();
        chk("r_pre_en", en[0], 1'b1);
        rst_n = 1'b0;
        rq.delete();
        #1;
        chk("r_async_en", en[0], 1'b0);
        chk("r_async_addr", addr(0), 2'd0);
        chk("r_async_busy", bsy[0], 1'b0);
        chk("r_async_count", cnt[0], 3'd0);
        chk("r_async_ready", rdy[0], 1'b1);
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (en[0] || bsy[0]) seen = 1'b1;
        end
        chk("r_no_strobe", seen, 1'b0);
        chk("r_post_count", cnt[0], 3'd0);
        exp_q.delete();
        chk_order(0, 0);

        // Full FIFO behind a 15-cycle strobe
        push(1, 2'd0);
        push(1, 2'd1);
        push(1, 2'd2);
        push(1, 2'd3);
        push(1, 2'd1);
        chk("f_count_full", cnt[1], 3'd4);
        chk("f_ready_low", rdy[1], 1'b0);
        vld[1] = 1'b1;
        ad[1]  = 2'd2;
        w = 0;
        while (!rdy[1] && w < 50) begin
            tick();
            w++;
        end
        chk("f_holdoff", 32'(w), 32'd14);
        chk("f_count_pop", cnt[1], 3'd3);
        tick();
        vld[1] = 1'b0;
        chk("f_count_refill", cnt[1], 3'd4);
        drain(1);
        exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
        chk_order(1, 17);
        chk("b_addr_stable", 32'(viol[1]), 32'd0);

        // Zero gap, single-cycle pulse
        push(2, 2'd1);
        push(2, 2'd2);
        tick();
        chk("g_e2_en", en[2], 1'b1);
        chk("g_e2_addr", addr(2), 2'd1);
        tick();
        chk("g_e3_en", en[2], 1'b0);
        chk("g_e3_addr", addr(2), 2'd2);
        tick();
        chk("g_e4_en", en[2], 1'b1);
        chk("g_e4_addr", addr(2), 2'd2);
        tick();
        chk("g_e5_en", en[2], 1'b0);
        chk("g_e5_busy", bsy[2], 1'b0);
        exp_q = {2'd1, 2'd2};
        chk_order(2, 2);
        chk("c_addr_stable", 32'(viol[2]), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
